// File: rtl/png_chunk_ctrl.sv
`timescale 1ns/1ps
// png_chunk_ctrl
// Sequences one PNG file as a stream of 32-bit words: an optional signature,
// then the IHDR, IDAT and IEND chunks. Each chunk is a length word, a type
// word, the chunk data, and a CRC word. The type and data words are mirrored
// to an external CRC core, and the CRC result returned by that core is
// emitted as the last word of the chunk.
//
// Configuration macro: PNG_CHUNK_CTRL_SIG_EN
//   defined   - the 8-byte PNG signature is emitted before IHDR
//   undefined - the file starts directly with the IHDR length word
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   w_i, h_i, idat_len_i      picture width/height and IDAT length, latched on start_i
//   start_i                   start one file (accepted only while idle)
//   idat_val_i/_dat_i/_nb_i/_lst_i, idat_rdy_o   IDAT payload stream in
//   out_val_o/_dat_o/_nb_o/_lst_o, out_rdy_i     file word stream out
//   crc_start_o/_val_o/_dat_o/_nb_o/_lst_o       CRC core feed
//   crc_done_i, crc_i         CRC core result
//   busy_o, done_o            file in progress, file complete pulse
module png_chunk_ctrl #(
    parameter logic [7:0] BIT_DEPTH  = 8'd8,
    parameter logic [7:0] COLOR_TYPE = 8'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] w_i,
    input  logic [31:0] h_i,
    input  logic        start_i,
    input  logic [31:0] idat_len_i,
    input  logic        idat_val_i,
    input  logic [31:0] idat_dat_i,
    input  logic [1:0]  idat_nb_i,
    input  logic        idat_lst_i,
    output logic        idat_rdy_o,
    output logic        out_val_o,
    input  logic        out_rdy_i,
    output logic [31:0] out_dat_o,
    output logic [1:0]  out_nb_o,
    output logic        out_lst_o,
    output logic        crc_start_o,
    output logic        crc_val_o,
    output logic [31:0] crc_dat_o,
    output logic [1:0]  crc_nb_o,
    output logic        crc_lst_o,
    input  logic        crc_done_i,
    input  logic [31:0] crc_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [3:0] {
        IDLE, SIG, IHDR_HD, IHDR_DAT, IDAT_HD, IDAT_DAT, IEND_HD, CRC_WT, CRC_OUT
    } state_t;

    typedef enum logic [1:0] {CH_IHDR, CH_IDAT, CH_IEND} chunk_t;

    localparam logic [31:0] SIG_WORD0 = 32'h8950_4E47;
    localparam logic [31:0] SIG_WORD1 = 32'h0D0A_1A0A;
    localparam logic [31:0] TYPE_IHDR = 32'h4948_4452;
    localparam logic [31:0] TYPE_IDAT = 32'h4944_4154;
    localparam logic [31:0] TYPE_IEND = 32'h4945_4E44;
    localparam logic [31:0] IHDR_LEN  = 32'd13;

    state_t      r_state, w_state_d;
    logic [1:0]  r_idx, w_idx_d;        // word index inside SIG, *_HD, IHDR_DAT
    logic [31:0] r_w, w_w_d;
    logic [31:0] r_h, w_h_d;
    logic [31:0] r_len, w_len_d;
    logic [31:0] r_crc, w_crc_d;
    chunk_t      r_chunk, w_chunk_d;    // chunk whose CRC is pending / being sent
    logic        r_done, w_done_d;

    logic w_xfer;
    logic w_fed;        // current word goes to the CRC core
    logic w_last;       // current word is the last CRC-fed word of the chunk
    logic w_len_word;   // current word is a chunk length word

    // Output word selection; purely a function of state and the payload stream.
    always_comb begin
        out_val_o  = 1'b0;
        out_dat_o  = 32'h0;
        out_nb_o   = 2'd0;
        out_lst_o  = 1'b0;
        idat_rdy_o = 1'b0;
        w_fed      = 1'b0;
        w_last     = 1'b0;
        w_len_word = 1'b0;
        case (r_state)
            SIG: begin
                out_val_o = 1'b1;
                out_nb_o  = 2'd3;
                out_dat_o = (r_idx == 2'd0) ? SIG_WORD0 : SIG_WORD1;
            end
            IHDR_HD, IDAT_HD, IEND_HD: begin
                out_val_o = 1'b1;
                out_nb_o  = 2'd3;
                if (r_idx == 2'd0) begin
                    w_len_word = 1'b1;
                    if (r_state == IHDR_HD) begin
                        out_dat_o = IHDR_LEN;
                    end else if (r_state == IDAT_HD) begin
                        out_dat_o = r_len;
                    end
                end else begin
                    w_fed = 1'b1;
                    if (r_state == IHDR_HD) begin
                        out_dat_o = TYPE_IHDR;
                    end else if (r_state == IDAT_HD) begin
                        out_dat_o = TYPE_IDAT;
                        w_last    = (r_len == 32'h0);
                    end else begin
                        out_dat_o = TYPE_IEND;
                        w_last    = 1'b1;
                    end
                end
            end
            IHDR_DAT: begin
                out_val_o = 1'b1;
                out_nb_o  = 2'd3;
                w_fed     = 1'b1;
                case (r_idx)
                    2'd0:    out_dat_o = r_w;
                    2'd1:    out_dat_o = r_h;
                    2'd2:    out_dat_o = {BIT_DEPTH, COLOR_TYPE, 8'h00, 8'h00};
                    default: begin
                        // Interlace byte, MSB-aligned, single byte valid
                        out_dat_o = 32'h0;
                        out_nb_o  = 2'd0;
                        w_last    = 1'b1;
                    end
                endcase
            end
            IDAT_DAT: begin
                out_val_o  = idat_val_i;
                out_dat_o  = idat_dat_i;
                out_nb_o   = idat_nb_i;
                idat_rdy_o = out_rdy_i;
                w_fed      = 1'b1;
                w_last     = idat_lst_i;
            end
            CRC_OUT: begin
                out_val_o = 1'b1;
                out_dat_o = r_crc;
                out_nb_o  = 2'd3;
                out_lst_o = (r_chunk == CH_IEND);
            end
            default: ;
        endcase
    end

    assign w_xfer      = out_val_o & out_rdy_i;
    assign crc_start_o = w_xfer & w_len_word;
    assign crc_val_o   = w_xfer & w_fed;
    assign crc_lst_o   = w_xfer & w_fed & w_last;
    assign crc_dat_o   = w_fed ? out_dat_o : 32'h0;
    assign crc_nb_o    = w_fed ? out_nb_o : 2'd0;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_w_d     = r_w;
        w_h_d     = r_h;
        w_len_d   = r_len;
        w_crc_d   = r_crc;
        w_chunk_d = r_chunk;
        w_done_d  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_w_d   = w_i;
                    w_h_d   = h_i;
                    w_len_d = idat_len_i;
                    w_idx_d = 2'd0;
`ifdef PNG_CHUNK_CTRL_SIG_EN
                    w_state_d = SIG;
`else
                    w_state_d = IHDR_HD;
`endif
                end
            end
            SIG: begin
                if (w_xfer) begin
                    if (r_idx == 2'd1) begin
                        w_idx_d   = 2'd0;
                        w_state_d = IHDR_HD;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end
            end
            IHDR_HD: begin
                if (w_xfer) begin
                    if (r_idx == 2'd1) begin
                        w_idx_d   = 2'd0;
                        w_state_d = IHDR_DAT;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end
            end
            IHDR_DAT: begin
                if (w_xfer) begin
                    if (r_idx == 2'd3) begin
                        w_idx_d   = 2'd0;
                        w_chunk_d = CH_IHDR;
                        w_state_d = CRC_WT;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end
            end
            IDAT_HD: begin
                if (w_xfer) begin
                    if (r_idx == 2'd1) begin
                        w_idx_d   = 2'd0;
                        w_chunk_d = CH_IDAT;
                        w_state_d = (r_len == 32'h0) ? CRC_WT : IDAT_DAT;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end
            end
            IDAT_DAT: begin
                if (w_xfer && idat_lst_i) begin
                    w_state_d = CRC_WT;
                end
            end
            IEND_HD: begin
                if (w_xfer) begin
                    if (r_idx == 2'd1) begin
                        w_idx_d   = 2'd0;
                        w_chunk_d = CH_IEND;
                        w_state_d = CRC_WT;
                    end else begin
                        w_idx_d = r_idx + 2'd1;
                    end
                end
            end
            CRC_WT: begin
                if (crc_done_i) begin
                    w_crc_d   = crc_i;
                    w_state_d = CRC_OUT;
                end
            end
            CRC_OUT: begin
                if (w_xfer) begin
                    case (r_chunk)
                        CH_IHDR: w_state_d = IDAT_HD;
                        CH_IDAT: w_state_d = IEND_HD;
                        default: begin
                            w_state_d = IDLE;
                            w_done_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_w     <= 32'h0;
            r_h     <= 32'h0;
            r_len   <= 32'h0;
            r_crc   <= 32'h0;
            r_chunk <= CH_IHDR;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_w     <= w_w_d;
            r_h     <= w_h_d;
            r_len   <= w_len_d;
            r_crc   <= w_crc_d;
            r_chunk <= w_chunk_d;
            r_done  <= w_done_d;
        end
    end

endmodule
